oled_region_arbiter: RTL and testbench
======================================

OLED_REGION_ARBITER -- requirements
Module: oled_region_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles required before a switch level is accepted.
REQ-002 Parameter HOLD_FRAMES, default 30: frames a grant is held before rotating to another pending requester.
REQ-003 Parameter FG_COLOUR, default 16'hFFFF: pixel value for the granted region.
REQ-004 Port CLK, input, 1: single system clock; all state on its rising edge.
REQ-005 Port RST, input, 1: reset, synchronous and active-high.
REQ-006 Port SW1 / SW2 / SW3, input, 1 each: raw, asynchronous, bouncing slide switches requesting regions 1 / 2 / 3.
REQ-007 Port frame_begin, input, 1: single-cycle pulse marking the start of each OLED frame.
REQ-008 Port x, input, 7: current pixel column, 0..95.
REQ-009 Port y, input, 6: current pixel row, 0..63; carried for interface compatibility, no functional effect.
REQ-010 Port olede, output, 16: pixel colour for (x, y).
REQ-011 Port grant, output, 3: one-hot granted region (bit0 = SW1), or 3'b000 when idle.
REQ-012 Port active_region, output, 2: encoded grant: 0 = none, 1..3 = region.

Function
REQ-013 Each SWn passes through a 2-flop synchronizer before any other use.
REQ-014 Debounce: req[n] takes the synchronized level only after that level has differed from req[n] for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-015 FSM states: IDLE (grant = 0) and ACTIVE (exactly one grant bit set).
REQ-016 grant changes only on the cycle after a frame_begin pulse, never mid-frame.
REQ-017 In IDLE, at frame_begin with any req set: grant the first set request at or after rr_ptr (cyclic order 1 -> 2 -> 3), then enter ACTIVE.
REQ-018 In ACTIVE, at frame_begin with the granted req deasserted: grant the next set request after the current one in cyclic order; if none is set, go to IDLE.
REQ-019 In ACTIVE, at frame_begin with the granted req still set: increment frame_cnt.
REQ-020 When frame_cnt reaches HOLD_FRAMES and another req is set, rotate to the next set request in cyclic order.
REQ-021 When frame_cnt reaches HOLD_FRAMES and no other req is set, keep the grant and saturate frame_cnt at HOLD_FRAMES.
REQ-022 On every grant change: frame_cnt := 0 and rr_ptr := newly granted index.
REQ-023 Simultaneous req edges at one frame_begin are resolved by REQ-017/018 cyclic order only; no request is lost while still asserted.
REQ-024 Region map: region 1 is x 0..31, region 2 is x 32..63, region 3 is x 64..95.
REQ-025 olede is registered with 1-cycle latency from x: FG_COLOUR when x is inside the granted region, else 16'h0000.
REQ-026 olede is 16'h0000 when x > 95 or when grant = 0.
REQ-027 active_region and grant are registered and mutually consistent on every cycle.

Reset
REQ-028 While RST is high on a rising edge, clear: synchronizers, debounce counters, req to 0, FSM to IDLE, grant to 0, active_region to 0, frame_cnt to 0, rr_ptr to region 1, olede to 16'h0000.
REQ-029 RST asserted mid-frame or mid-hold takes effect on the same edge with no partial state retained.
REQ-030 After RST release, no grant is issued before a full debounce plus the next frame_begin.

Structure
REQ-031 A shared package holds the region boundary constants (32, 64, 96), the FSM state typedef, and region encodings.
REQ-032 One sub-module, switch_debounce (synchronizer plus counter, parameterized by DEBOUNCE_CYCLES), is instantiated three times.

Verification (DEBOUNCE_CYCLES=4, HOLD_FRAMES=2)
REQ-033 Reset/idle: RST for 3 cycles, switches low, 5 frame_begin pulses -> grant=000, active_region=0, olede=0 for all x.
REQ-034 Debounce: SW1 toggles every 2 cycles for 20 cycles, then stays high -> req[0] rises exactly 4+2 cycles after the final rise; grant=001 on the cycle after the next frame_begin; olede=FFFF for x=0..31, 0 for x=32 and x=95, with 1-cycle latency.
REQ-035 Rotation: SW1 and SW3 held high -> grant 001 for 2 frames, then 100 for 2 frames, then 001; frame_cnt resets at each switch.
REQ-036 Drop: granted SW2 released mid-frame -> grant stays 010 until the next frame_begin (after debounce), then becomes 000 or the next pending region.
REQ-037 Boundary: x=31 -> FFFF and x=32 -> 0 under grant 001; x=96..127 -> 0 under grant 100.
REQ-038 Reset mid-operation: RST pulsed while ACTIVE with frame_cnt=1 -> next cycle grant=000 and olede=0; re-grant only after debounce plus frame_begin.

Source files
------------

// File: rtl/oled_region_arbiter_pkg.sv
// oled_region_arbiter_pkg: region bounds, FSM states, region encodings and the cyclic request search.
package oled_region_arbiter_pkg;
   localparam logic [6:0] REGION2_X = 7'd32;
   localparam logic [6:0] REGION3_X = 7'd64;
   localparam logic [6:0] X_LIMIT   = 7'd96;
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_ACTIVE = 1'b1;
   localparam logic [1:0] AR_NONE = 2'd0;
   localparam logic [1:0] AR_R1   = 2'd1;
   localparam logic [1:0] AR_R2   = 2'd2;
   localparam logic [1:0] AR_R3   = 2'd3;
   function automatic logic [1:0] inc3(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction
   // Returns {found, index} of the first set request at or after start in 0 -> 1 -> 2 order.
   function automatic logic [2:0] first_set(input logic [2:0] req, input logic [1:0] start);
      logic [1:0] a, b;
      a = inc3(start);
      b = inc3(a);
      return req[start] ? {1'b1, start} : req[a] ? {1'b1, a} : req[b] ? {1'b1, b} : 3'b000;
   endfunction
endpackage

// File: rtl/oled_region_arbiter_switch_debounce.sv
// switch_debounce: 2-flop synchronizer followed by a consecutive-cycle stability filter.
module switch_debounce
   import oled_region_arbiter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic req_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   logic [1:0] sync_q;
   logic req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      req_d = req_q;
      cnt_d = '0;
      if (sync_q[1] != req_q) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
         req_d = (cnt_q == LAST) ? sync_q[1] : req_q;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b00;
         req_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], sw_i};
         req_q  <= req_d;
         cnt_q  <= cnt_d;
      end
   end
   assign req_o = req_q;
endmodule

// File: rtl/oled_region_arbiter.sv
// oled_region_arbiter: frame-aligned round-robin grant of three OLED column regions to debounced switches,
// painting the granted region in FG_COLOUR.
module oled_region_arbiter
   import oled_region_arbiter_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 65536,
   parameter int          HOLD_FRAMES     = 30,
   parameter logic [15:0] FG_COLOUR       = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SW1,
   input  logic        SW2,
   input  logic        SW3,
   input  logic        frame_begin,
   input  logic [6:0]  x,
   input  logic [5:0]  y,
   output logic [15:0] olede,
   output logic [2:0]  grant,
   output logic [1:0]  active_region
);
   localparam int CW = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW-1:0] HOLD    = CW'(HOLD_FRAMES);
   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_FRAMES - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);
   logic [2:0] req, grant_q, grant_d, pick_idle, pick_next, move_idx;
   logic [1:0] ar_q, ar_d, rr_q, rr_d, cur, x_region;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] olede_q, olede_d;
   logic unused_y;
   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (.clk_i(CLK), .rst_i(RST), .sw_i(SW1), .req_o(req[0]));
   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (.clk_i(CLK), .rst_i(RST), .sw_i(SW2), .req_o(req[1]));
   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw3 (.clk_i(CLK), .rst_i(RST), .sw_i(SW3), .req_o(req[2]));
   assign unused_y  = ^y;
   assign cur       = ar_q - 2'd1;
   assign pick_idle = first_set(req, rr_q);
   assign pick_next = first_set(req, inc3(cur));
   assign move_idx  = (state_q == ST_IDLE) ? pick_idle : pick_next;
   assign x_region  = (x < REGION2_X) ? AR_R1 : (x < REGION3_X) ? AR_R2 : AR_R3;
   assign olede_d   = (ar_q != AR_NONE && x < X_LIMIT && x_region == ar_q) ? FG_COLOUR : 16'h0000;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ar_d    = ar_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      if (frame_begin) begin
         // Keep the owner while its hold is unfinished or nobody else is waiting.
         if (state_q == ST_ACTIVE && req[cur] && (cnt_q < HOLD_M1 || pick_next[1:0] == cur)) begin
            cnt_d = (cnt_q == HOLD) ? HOLD : cnt_q + ONE;
         end else if (move_idx[2]) begin
            state_d = ST_ACTIVE;
            grant_d = 3'b001 << move_idx[1:0];
            ar_d    = move_idx[1:0] + 2'd1;
            rr_d    = move_idx[1:0];
            cnt_d   = '0;
         end else begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            ar_d    = AR_NONE;
            cnt_d   = '0;
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         grant_q <= 3'b000;
         ar_q    <= AR_NONE;
         rr_q    <= 2'd0;
         cnt_q   <= '0;
         olede_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ar_q    <= ar_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         olede_q <= olede_d;
      end
   end
   assign grant         = grant_q;
   assign active_region = ar_q;
   assign olede         = olede_q;
endmodule

// File: tb/tb_oled_region_arbiter.sv
// tb_oled_region_arbiter: directed scenarios checked every cycle against a behavioural model plus literal expectations.
module tb_oled_region_arbiter;
   localparam int DEB  = 4;
   localparam int HOLD = 2;
   logic CLK = 0, RST = 1, SW1 = 0, SW2 = 0, SW3 = 0, frame_begin = 0;
   logic [6:0] x = 0;
   logic [5:0] y = 0;
   logic [15:0] olede;
   logic [2:0] grant, g;
   logic [1:0] active_region;
   int vectors = 0, miscompares = 0, n;
   bit chk_on = 0;
   logic [6:0] xs [16] = '{7'd0, 7'd5, 7'd31, 7'd32, 7'd40, 7'd63, 7'd64, 7'd80,
                           7'd95, 7'd96, 7'd100, 7'd127, 7'd10, 7'd50, 7'd70, 7'd20};
   logic [2:0] rot_exp [7] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001, 3'b100};
   bit [2:0] m_s1, m_s2, m_req;
   int m_run [3];
   int owner, frames, last;
   logic [15:0] m_olede;

   oled_region_arbiter #(.DEBOUNCE_CYCLES(DEB), .HOLD_FRAMES(HOLD), .FG_COLOUR(16'hFFFF)) dut (
      .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .SW3(SW3), .frame_begin(frame_begin),
      .x(x), .y(y), .olede(olede), .grant(grant), .active_region(active_region));

   always #5 CLK = ~CLK;

   function automatic int scan(input int from, input bit [2:0] r);
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (from - 1 + k) % 3 + 1;
         if (r[idx-1]) return idx;
      end
      return 0;
   endfunction

   // Model: switches seen two cycles late, accepted after DEB differing cycles; grants move only at frame_begin.
   always @(posedge CLK) begin : model
      int nxt;
      if (RST) begin
         m_s1 = 0; m_s2 = 0; m_req = 0; m_run = '{0, 0, 0};
         owner = 0; frames = 0; last = 1; m_olede = 16'h0000;
      end else begin
         m_olede = (owner != 0 && int'(x) < 96 && int'(x) / 32 + 1 == owner) ? 16'hFFFF : 16'h0000;
         if (frame_begin) begin
            if (owner == 0) begin
               owner = scan(last, m_req);
               if (owner != 0) begin last = owner; frames = 0; end
            end else if (!m_req[owner-1]) begin
               owner = scan(owner % 3 + 1, m_req);
               frames = 0;
               if (owner != 0) last = owner;
            end else begin
               nxt = scan(owner % 3 + 1, m_req);
               if (frames + 1 >= HOLD && nxt != owner) begin owner = nxt; last = nxt; frames = 0; end
               else frames = (frames + 1 > HOLD) ? HOLD : frames + 1;
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (m_s2[k] != m_req[k]) begin
               m_run[k]++;
               if (m_run[k] == DEB) begin m_req[k] = m_s2[k]; m_run[k] = 0; end
            end else m_run[k] = 0;
         end
         m_s2 = m_s1;
         m_s1 = {SW3, SW2, SW1};
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) if (chk_on) begin
      check("model_grant", {13'd0, grant}, (owner == 0) ? 16'd0 : 16'(3'b001 << (owner - 1)));
      check("model_active_region", {14'd0, active_region}, 16'(owner));
      check("model_olede", olede, m_olede);
   end

   task automatic tick(input int k);
      repeat (k) begin @(posedge CLK); #1; end
   endtask

   task automatic reset3();
      RST = 1; tick(3); RST = 0;
   endtask

   task automatic frame(output logic [2:0] gr);
      frame_begin = 1; tick(1); gr = grant; frame_begin = 0;
      for (int i = 0; i < 12; i++) begin x = xs[i]; tick(1); end
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick(1); chk_on = 1; tick(2); RST = 0;
      // reset and idle
      check("rst_grant", {13'd0, grant}, 16'h0000);
      check("rst_region", {14'd0, active_region}, 16'h0000);
      check("rst_olede", olede, 16'h0000);
      for (int f = 0; f < 5; f++) begin frame(g); check("idle_grant", {13'd0, g}, 16'h0000); end
      // debounce of a bouncing SW1
      for (int i = 0; i < 10; i++) begin SW1 = ~SW1; tick(2); end
      check("bounce_no_req", {15'd0, dut.u_sw1.req_o}, 16'h0000);
      SW1 = 1; n = 0;
      while (!dut.u_sw1.req_o && n < 50) begin tick(1); n++; end
      check("deb_latency", 16'(n), 16'd6);
      check("pre_frame_grant", {13'd0, grant}, 16'h0000);
      frame_begin = 1; tick(1); frame_begin = 0;
      check("deb_grant", {13'd0, grant}, 16'h0001);
      check("deb_region", {14'd0, active_region}, 16'h0001);
      x = 0;  tick(1); check("x0", olede, 16'hFFFF);
      x = 31; tick(1); check("x31", olede, 16'hFFFF);
      x = 32; check("x32_latency", olede, 16'hFFFF);
      tick(1); check("x32", olede, 16'h0000);
      x = 95; tick(1); check("x95", olede, 16'h0000);
      // rotation between SW1 and SW3
      SW1 = 0; reset3();
      SW1 = 1; SW3 = 1; tick(10);
      for (int f = 0; f < 7; f++) begin frame(g); check("rotate", {13'd0, g}, {13'd0, rot_exp[f]}); end
      // drop of granted SW2 mid-frame
      SW1 = 0; SW3 = 0; reset3();
      SW2 = 1; tick(10);
      frame(g); check("drop_grant2", {13'd0, g}, 16'h0002);
      SW2 = 0; SW3 = 1; tick(8);
      check("drop_hold_midframe", {13'd0, grant}, 16'h0002);
      frame(g); check("drop_next3", {13'd0, g}, 16'h0004);
      for (int i = 96; i < 128; i++) begin x = 7'(i); tick(1); check("x_over95", olede, 16'h0000); end
      x = 70; tick(1); check("x70_r3", olede, 16'hFFFF);
      SW3 = 0; tick(8);
      frame(g); check("drop_idle", {13'd0, g}, 16'h0000);
      // reset mid-hold
      reset3();
      SW1 = 1; tick(10);
      frame(g); check("mid_grant", {13'd0, g}, 16'h0001);
      frame(g); check("mid_hold", {13'd0, g}, 16'h0001);
      x = 5; tick(3);
      check("mid_olede_before", olede, 16'hFFFF);
      RST = 1; tick(1); RST = 0;
      check("mid_rst_grant", {13'd0, grant}, 16'h0000);
      check("mid_rst_olede", olede, 16'h0000);
      frame(g); check("mid_no_early_grant", {13'd0, g}, 16'h0000);
      tick(2);
      frame(g); check("mid_regrant", {13'd0, g}, 16'h0001);
      tick(2);
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
